// File: rtl/mac_pe.sv
// mac_pe -- pipelined multiply-accumulate processing element.
//
// Accepts operand pairs over a valid/ready handshake, multiplies them and
// accumulates the products. The beat flagged in_last closes the vector: the
// dot product, its beat count and a sticky overflow flag are loaded into the
// output register, and the accumulator restarts from zero on the same edge.
//
// Pipeline: S1 operand regs -> S2 product reg -> S3 accumulate / output load.
// A downstream stall (out_valid && !out_ready) freezes every stage.
//
// Ports:
//   clk, rst            clock (rising), async active-high reset
//   in_valid/in_ready   operand beat handshake
//   in_a, in_b          operands (DATA_W)
//   in_last             final beat of the current vector
//   out_valid/out_ready result handshake
//   out_data            accumulated dot product (ACC_W)
//   out_len             beats in the vector, saturating (LEN_W)
//   out_ovf             overflow seen on any step of the vector
//   busy                beat in flight or partial vector held
module mac_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int SIGNED = 1,
  parameter int SAT    = 1,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_ovf,
  output logic              busy
);

  localparam int PW = 2 * DATA_W;

  logic              w_stall;
  logic              w_vld0;
  logic [2:1]        r_vld_pipe;
  logic [2:1]        r_last_pipe;
  logic [DATA_W-1:0] r_a, r_b;
  logic [PW-1:0]     r_prod;
  logic [PW-1:0]     w_a_ext, w_b_ext, w_prod;
  logic [ACC_W-1:0]  w_ext;
  logic [ACC_W:0]    w_sum;
  logic              w_ovf;
  logic [ACC_W-1:0]  w_sat_val;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_ovf;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_data;
  logic [LEN_W-1:0]  r_out_len;
  logic              r_out_ovf;

  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_vld0   = in_valid & in_ready;

  // Operands are widened to the product width first so the multiply is
  // exact in PW bits for both signed and unsigned interpretations.
  generate
    if (SIGNED != 0) begin : g_signed
      assign w_a_ext = PW'($signed(r_a));
      assign w_b_ext = PW'($signed(r_b));
      assign w_ext   = ACC_W'($signed(r_prod));
    end else begin : g_unsigned
      assign w_a_ext = PW'(r_a);
      assign w_b_ext = PW'(r_b);
      assign w_ext   = ACC_W'(r_prod);
    end
  endgenerate

  assign w_prod = w_a_ext * w_b_ext;
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_ext};

  // Signed overflow: both addends share a sign that the sum does not.
  assign w_ovf = (SIGNED != 0)
               ? ((r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]))
               : w_sum[ACC_W];

  // A signed overflow direction follows the (shared) addend sign; unsigned
  // addition can only overflow upwards.
  assign w_sat_val = (SIGNED != 0)
                   ? (r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                   : {ACC_W{1'b1}};

  assign w_acc_nxt = (w_ovf && (SAT != 0)) ? w_sat_val : w_sum[ACC_W-1:0];
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_prod      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_len   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      r_vld_pipe  <= {r_vld_pipe[1], w_vld0};
      r_last_pipe <= {r_last_pipe[1], in_last};
      if (w_vld0) begin
        r_a <= in_a;
        r_b <= in_b;
      end
      r_prod <= w_prod;

      // Not stalled means the current result (if any) is being taken.
      r_out_valid <= 1'b0;
      if (r_vld_pipe[2]) begin
        if (r_last_pipe[2]) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_acc_nxt;
          r_out_len   <= w_cnt_nxt;
          r_out_ovf   <= r_ovf | w_ovf;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_nxt;
          r_ovf <= r_ovf | w_ovf;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_len   = r_out_len;
  assign out_ovf   = r_out_ovf;

  // The counter only returns to zero when a vector closes, so a non-zero
  // count marks a partial vector held in the accumulator.
  assign busy = (|r_vld_pipe) | (|r_cnt);

endmodule
